// File: rtl/conv_core_pkg.sv
// Shared types and arithmetic helpers for the 1x1 convolution feature-map core.
package conv_core_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Widest accumulator the rounding/saturation helper handles.
  localparam int ACCW_MAX = 128;
  typedef logic signed [ACCW_MAX-1:0] acc_t;

  function automatic int calc_accw(input int dwidth, input int nch);
    return 2 * dwidth + $clog2(nch) + 1;
  endfunction

  // Round half up at the binary point, then clamp to a signed dwidth-bit range.
  function automatic acc_t sat_round(input acc_t sum, input int frac, input int dwidth);
    acc_t rounded;
    acc_t hi;
    acc_t lo;
    rounded = (sum + (acc_t'(1) <<< (frac - 1))) >>> frac;
    hi      = (acc_t'(1) <<< (dwidth - 1)) - acc_t'(1);
    lo      = -(acc_t'(1) <<< (dwidth - 1));
    if (rounded > hi) return hi;
    if (rounded < lo) return lo;
    return rounded;
  endfunction

endpackage

// File: rtl/conv_obuf_fifo.sv
// Small synchronous holding FIFO between the conv pipeline and the output FIFO port.
module conv_obuf_fifo
  import conv_core_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push,
  input  logic [DWIDTH-1:0]                   push_data,
  input  logic                                pop,
  output logic [$clog2(OBUF_DEPTH+1)-1:0]     count,
  output logic [DWIDTH-1:0]                   head
);

  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  logic [DWIDTH-1:0] mem [OBUF_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(OBUF_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(OBUF_DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: head is only consumed while count is non-zero.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/core_featuremap_conv1x1_param.sv
// 1x1 convolution core: lockstep reads from NCH input FIFOs, weighted sum + bias,
// round/saturate/ReLU, and a credit-limited output buffer feeding the output FIFO.
module core_featuremap_conv1x1_param
  import conv_core_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int FRAC       = 16,
  parameter int NCH        = 8,
  parameter int PIXELS     = 1024,
  parameter int RELU_EN    = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  output logic                        done,
  output logic                        busy,
  input  logic                        cfg_we,
  input  logic [$clog2(NCH+1)-1:0]    cfg_addr,
  input  logic [DWIDTH-1:0]           cfg_wdata,
  input  logic [NCH*DWIDTH-1:0]       ff_rdata,
  input  logic [NCH-1:0]              ff_empty,
  output logic                        ff_rdreq,
  output logic [DWIDTH-1:0]           ff_wdata,
  output logic                        ff_wrreq,
  input  logic                        ff_full
);

  // state | meaning
  // IDLE  | waiting for start, weights/bias writable
  // RUN   | issuing reads until PIXELS reads have been made
  // DRAIN | pipeline and obuf emptying into the output FIFO
  // DONE  | one-cycle done pulse

  localparam int AW   = $clog2(NCH + 1);
  localparam int ACCW = calc_accw(DWIDTH, NCH);
  localparam int PW   = $clog2(PIXELS + 1);
  localparam int CW   = $clog2(OBUF_DEPTH + 1);

  typedef logic signed [DWIDTH-1:0]   word_t;
  typedef logic signed [2*DWIDTH-1:0] prod_t;
  typedef logic signed [ACCW-1:0]     sum_t;

  state_t            state;
  state_t            state_nxt;
  logic [PW-1:0]     issued;
  logic [PW-1:0]     written;
  word_t             weight [NCH];
  word_t             bias;

  logic              rd_valid;
  logic              p1_valid;
  logic              p2_valid;
  logic              p3_valid;
  word_t             p1_x    [NCH];
  prod_t             p2_prod [NCH];
  sum_t              p3_sum;
  sum_t              tree_sum;
  acc_t              rounded;
  logic [DWIDTH-1:0] result;

  logic [CW-1:0]     obuf_count;
  logic [DWIDTH-1:0] obuf_head;
  logic [DWIDTH-1:0] last_wdata;
  logic [2:0]        inflight;
  logic              credit_ok;
  logic              pipe_empty;
  logic              frame_start;

  assign inflight    = 3'(rd_valid) + 3'(p1_valid) + 3'(p2_valid) + 3'(p3_valid);
  assign credit_ok   = (int'(obuf_count) + int'(inflight)) < OBUF_DEPTH;
  assign pipe_empty  = !(rd_valid || p1_valid || p2_valid || p3_valid);
  assign frame_start = (state == IDLE) && start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issued == PW'(PIXELS)) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty && (obuf_count == '0) && (written == PW'(PIXELS)))
                 state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
    ff_rdreq = (state == RUN) && (ff_empty == '0) && (issued < PW'(PIXELS)) && credit_ok;
    ff_wrreq = (obuf_count != '0) && !ff_full;
    ff_wdata = ff_wrreq ? obuf_head : last_wdata;
  end

  // Weight/bias register file, frozen outside IDLE so a frame sees one set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) weight[c] <= '0;
      bias <= '0;
    end else if (cfg_we && (state == IDLE)) begin
      if (cfg_addr == AW'(NCH)) bias <= cfg_wdata;
      for (int c = 0; c < NCH; c++)
        if (cfg_addr == AW'(c)) weight[c] <= cfg_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued     <= '0;
      written    <= '0;
      last_wdata <= '0;
    end else begin
      if (frame_start) begin
        issued  <= '0;
        written <= '0;
      end else begin
        if (ff_rdreq) issued  <= issued + PW'(1);
        if (ff_wrreq) written <= written + PW'(1);
      end
      if (ff_wrreq) last_wdata <= obuf_head;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
      p3_valid <= 1'b0;
      p3_sum   <= '0;
      for (int c = 0; c < NCH; c++) begin
        p1_x[c]    <= '0;
        p2_prod[c] <= '0;
      end
    end else begin
      rd_valid <= ff_rdreq;
      p1_valid <= rd_valid;
      p2_valid <= p1_valid;
      p3_valid <= p2_valid;
      for (int c = 0; c < NCH; c++) begin
        if (rd_valid) p1_x[c]    <= ff_rdata[c*DWIDTH +: DWIDTH];
        if (p1_valid) p2_prod[c] <= prod_t'(p1_x[c]) * prod_t'(weight[c]);
      end
      if (p2_valid) p3_sum <= tree_sum;
    end
  end

  // Bias is aligned to the product binary point (2*FRAC) before summation.
  always_comb begin
    tree_sum = sum_t'(bias) <<< FRAC;
    for (int c = 0; c < NCH; c++) tree_sum = tree_sum + sum_t'(p2_prod[c]);
  end

  always_comb begin
    rounded = sat_round(acc_t'(p3_sum), FRAC, DWIDTH);
    if ((RELU_EN != 0) && (rounded < 0)) rounded = '0;
    result = rounded[DWIDTH-1:0];
  end

  conv_obuf_fifo #(
    .DWIDTH     (DWIDTH),
    .OBUF_DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clock     (clock),
    .reset     (reset),
    .push      (p3_valid),
    .push_data (result),
    .pop       (ff_wrreq),
    .count     (obuf_count),
    .head      (obuf_head)
  );

endmodule

// File: tb/tb_core_featuremap_conv1x1_param.sv
// Bench: two cores (ReLU off / on) share one input FIFO model and are checked
// against an arithmetic reference of the weighted sum, rounding and clamping.
module tb_core_featuremap_conv1x1_param;

  localparam int DW    = 32;
  localparam int FRAC  = 16;
  localparam int NCH   = 8;
  localparam int PIX   = 16;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(NCH + 1);
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef logic signed [127:0] wide_t;
  typedef logic [DW-1:0]       word_t;
  typedef logic [NCH*DW-1:0]   pvec_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [DW-1:0]     cfg_wdata;
  logic [NCH*DW-1:0] ff_rdata;
  logic [NCH-1:0]    ff_empty;
  logic              ff_full;
  logic [1:0]        done_v, busy_v, rdreq_v, wrreq_v;
  logic [DW-1:0]     wdata_v [2];

  always #5 clock = ~clock;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    core_featuremap_conv1x1_param #(
      .DWIDTH(DW), .FRAC(FRAC), .NCH(NCH), .PIXELS(PIX), .RELU_EN(d), .OBUF_DEPTH(DEPTH)
    ) u_dut (
      .clock(clock), .reset(reset), .start(start), .done(done_v[d]), .busy(busy_v[d]),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .ff_rdata(ff_rdata), .ff_empty(ff_empty), .ff_rdreq(rdreq_v[d]),
      .ff_wdata(wdata_v[d]), .ff_wrreq(wrreq_v[d]), .ff_full(ff_full)
    );
  end

  // reference state
  word_t   w_m [NCH];
  word_t   b_m;
  pvec_t   in_q[$];
  word_t   exp_q0[$];
  word_t   exp_q1[$];
  word_t   last_w [2];
  word_t   first_out [2];
  bit      got_first [2];
  bit      rd_pend;
  int      gap_pct, full_pct;
  int      rd_total, wr_total, frame_rd, done_cnt;
  int      n_chk, n_pass;

  // next-cycle drive values, applied just after each rising edge
  logic          start_n, full_n, cfg_we_n;
  logic [AW-1:0] cfg_addr_n;
  word_t         cfg_wdata_n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic word_t ref_pix(input pvec_t x, input bit relu);
    wide_t acc, r;
    acc = wide_t'($signed(b_m)) * wide_t'(2 ** FRAC);
    for (int c = 0; c < NCH; c++)
      acc += wide_t'($signed(w_m[c])) * wide_t'($signed(x[c*DW +: DW]));
    r = (acc + wide_t'(2 ** (FRAC - 1))) >>> FRAC;
    if (r > wide_t'(SMAX)) r = wide_t'(SMAX);
    if (r < wide_t'(SMIN)) r = wide_t'(SMIN);
    if (relu && (r < 0)) r = '0;
    return r[DW-1:0];
  endfunction

  function automatic word_t rnd_fx();
    logic signed [18:0] s;
    s = 19'($urandom);
    if ($urandom_range(9) == 0) return word_t'($urandom);
    return {{13{s[18]}}, s};
  endfunction

  task automatic push_pix(input pvec_t x);
    in_q.push_back(x);
    exp_q0.push_back(ref_pix(x, 1'b0));
    exp_q1.push_back(ref_pix(x, 1'b1));
  endtask

  task automatic monitor();
    check("rd_lockstep", 64'(rdreq_v[1]), 64'(rdreq_v[0]));
    check("wr_lockstep", 64'(wrreq_v[1]), 64'(wrreq_v[0]));
    check("done_lockstep", 64'(done_v[1]), 64'(done_v[0]));
    check("rd_while_empty", 64'(rdreq_v[0] & (|ff_empty)), 64'(0));
    check("wr_while_full", 64'(wrreq_v[0] & ff_full), 64'(0));
    check("outstanding", 64'((rd_total + int'(rdreq_v[0]) - wr_total) <= DEPTH), 64'(1));
    for (int d = 0; d < 2; d++) begin
      if (wrreq_v[d]) begin
        if (!got_first[d]) begin
          first_out[d] = wdata_v[d];
          got_first[d] = 1'b1;
        end
        last_w[d] = wdata_v[d];
      end else begin
        check("wdata_hold", 64'(wdata_v[d]), 64'(last_w[d]));
      end
    end
    if (wrreq_v[0]) begin
      check("out_avail_norelu", 64'(exp_q0.size() != 0), 64'(1));
      if (exp_q0.size() != 0) check("wdata_norelu", 64'(wdata_v[0]), 64'(exp_q0.pop_front()));
    end
    if (wrreq_v[1]) begin
      check("out_avail_relu", 64'(exp_q1.size() != 0), 64'(1));
      if (exp_q1.size() != 0) check("wdata_relu", 64'(wdata_v[1]), 64'(exp_q1.pop_front()));
    end
    if (done_v[0]) done_cnt++;
    if (rdreq_v[0]) begin
      rd_total++;
      frame_rd++;
    end
    if (wrreq_v[0]) wr_total++;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    if (rd_pend && (in_q.size() != 0)) ff_rdata = in_q.pop_front();
    start     = start_n;
    ff_full   = full_n;
    cfg_we    = cfg_we_n;
    cfg_addr  = cfg_addr_n;
    cfg_wdata = cfg_wdata_n;
    for (int c = 0; c < NCH; c++)
      ff_empty[c] = (in_q.size() == 0) || ($urandom_range(99) < gap_pct);
    @(negedge clock);
    monitor();
    rd_pend = rdreq_v[0];
  endtask

  task automatic cfg_write(input int addr, input word_t data);
    cfg_we_n    = 1'b1;
    cfg_addr_n  = AW'(addr);
    cfg_wdata_n = data;
    cycle();
    cfg_we_n = 1'b0;
    if (addr == NCH) b_m = data;
    else             w_m[addr] = data;
  endtask

  task automatic load_uniform(input word_t w, input word_t b);
    for (int c = 0; c < NCH; c++) cfg_write(c, w);
    cfg_write(NCH, b);
  endtask

  task automatic load_random();
    for (int c = 0; c < NCH; c++) cfg_write(c, rnd_fx());
    cfg_write(NCH, rnd_fx());
  endtask

  task automatic push_random(input int n);
    pvec_t v;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NCH; c++) v[c*DW +: DW] = rnd_fx();
      push_pix(v);
    end
  endtask

  task automatic run_frame(input int full_at, input int full_len, input bit cfg_glitch);
    int cyc;
    bit hold;
    done_cnt  = 0;
    frame_rd  = 0;
    got_first = '{1'b0, 1'b0};
    start_n = 1'b1;
    cycle();
    start_n = 1'b0;
    cyc = 0;
    while ((done_cnt == 0) && (cyc < 3000)) begin
      hold        = (cyc >= full_at) && (cyc < full_at + full_len);
      full_n      = hold || ($urandom_range(99) < full_pct);
      cfg_we_n    = cfg_glitch && (cyc == 2);
      cfg_addr_n  = AW'($urandom_range(NCH));
      cfg_wdata_n = word_t'($urandom);
      cycle();
      if (hold && (cyc == full_at + full_len - 1))
        check("stall_rdreq", 64'(rdreq_v[0]), 64'(0));
      cyc++;
    end
    cfg_we_n = 1'b0;
    full_n   = 1'b0;
    check("frame_done", 64'(done_cnt), 64'(1));
    repeat (3) cycle();
    check("done_once", 64'(done_cnt), 64'(1));
    check("frame_reads", 64'(frame_rd), 64'(PIX));
    check("all_out_norelu", 64'(exp_q0.size()), 64'(0));
    check("all_out_relu", 64'(exp_q1.size()), 64'(0));
    check("idle_busy", 64'(busy_v[0]), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdreq"}, 64'(rdreq_v), 64'(0));
    check({tag, "_wrreq"}, 64'(wrreq_v), 64'(0));
    check({tag, "_busy"},  64'(busy_v),  64'(0));
    check({tag, "_done"},  64'(done_v),  64'(0));
    check({tag, "_wdata0"}, 64'(wdata_v[0]), 64'(0));
    check({tag, "_wdata1"}, 64'(wdata_v[1]), 64'(0));
  endtask

  task automatic clear_model();
    in_q.delete();
    exp_q0.delete();
    exp_q1.delete();
    rd_pend  = 1'b0;
    rd_total = 0;
    wr_total = 0;
    last_w   = '{word_t'(0), word_t'(0)};
    for (int c = 0; c < NCH; c++) w_m[c] = '0;
    b_m = '0;
  endtask

  initial begin
    pvec_t v;
    int    cyc;
    n_chk = 0; n_pass = 0;
    gap_pct = 0; full_pct = 0;
    start = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    ff_rdata = '0; ff_empty = '1; ff_full = 0;
    start_n = 0; full_n = 0; cfg_we_n = 0; cfg_addr_n = '0; cfg_wdata_n = '0;
    clear_model();
    reset = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // unit weights, x[c] = c: every output is 28.0
    load_uniform(32'h0001_0000, 32'h0);
    for (int c = 0; c < NCH; c++) v[c*DW +: DW] = word_t'(c) << FRAC;
    for (int i = 0; i < PIX; i++) push_pix(v);
    run_frame(10000, 0, 1'b0);
    check("t1_value_norelu", 64'(first_out[0]), 64'(32'h001C_0000));
    check("t1_value_relu", 64'(first_out[1]), 64'(32'h001C_0000));

    // single negative tap: ReLU clamps, plain path keeps -5.0
    load_uniform(32'h0, 32'h0);
    cfg_write(0, 32'hFFFF_0000);
    v = '0;
    v[DW-1:0] = 32'h0005_0000;
    for (int i = 0; i < PIX; i++) push_pix(v);
    run_frame(10000, 0, 1'b0);
    check("t2_neg_norelu", 64'(first_out[0]), 64'(32'hFFFB_0000));
    check("t2_neg_relu", 64'(first_out[1]), 64'(32'h0));

    // saturation at both rails
    load_uniform(32'h7FFF_FFFF, 32'h0);
    for (int c = 0; c < NCH; c++) v[c*DW +: DW] = 32'h7FFF_FFFF;
    push_pix(v);
    push_random(PIX - 1);
    run_frame(10000, 0, 1'b0);
    check("t3_sat_hi", 64'(first_out[0]), 64'(32'h7FFF_FFFF));
    load_uniform(32'h8000_0000, 32'h0);
    push_pix(v);
    push_random(PIX - 1);
    run_frame(10000, 0, 1'b0);
    check("t3_sat_lo_norelu", 64'(first_out[0]), 64'(32'h8000_0000));
    check("t3_sat_lo_relu", 64'(first_out[1]), 64'(32'h0));

    // output backpressure held for 20 cycles mid-frame
    load_random();
    push_random(PIX);
    run_frame(6, 20, 1'b0);

    // random frames with channel gaps, random backpressure and ignored RUN-time cfg writes
    gap_pct  = 30;
    full_pct = 20;
    for (int f = 0; f < 16; f++) begin
      if ((f % 3) == 0) load_random();
      push_random(PIX);
      run_frame(10000, 0, (f % 2) == 1);
    end
    gap_pct  = 0;
    full_pct = 0;

    // reset while draining with words still held in obuf
    load_random();
    push_random(PIX);
    done_cnt = 0;
    frame_rd = 0;
    start_n  = 1'b1;
    cycle();
    start_n = 1'b0;
    cyc = 0;
    while ((frame_rd < PIX) && (cyc < 500)) begin
      cycle();
      cyc++;
    end
    check("drain_reached", 64'(frame_rd), 64'(PIX));
    full_n = 1'b1;
    repeat (6) cycle();
    full_n = 1'b0;
    cycle();
    check("pre_reset_busy", 64'(busy_v[0]), 64'(1));
    check("pre_reset_wrreq", 64'(wrreq_v[0]), 64'(1));
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    clear_model();
    @(posedge clock);
    #1 reset = 1'b0;

    // weights were cleared by reset: a frame without reload yields zeros
    push_random(PIX);
    run_frame(10000, 0, 1'b0);
    check("post_reset_zero", 64'(first_out[0]), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
